// File: rtl/tx_pkt_fifo.sv
// Packet TX FIFO: words stay tentative until wr_commit publishes them to the reader; wr_discard drops them.
// Read latency 1 (rd_data registered); writes rejected while full, reads rejected while empty, both with sticky errors.
module tx_pkt_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 256,
    parameter int AFULL_THRESH = 16,
    parameter int ADDR_BITS    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_commit,
    input  logic                 wr_discard,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_BITS:0]   free,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 err_ovf,
    output logic                 err_udf,
    input  logic                 err_clr
);

    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE_W   = (ADDR_BITS+1)'(1);

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   rd_data_q;
    logic               rd_valid_q;
    logic               err_ovf_q, err_ovf_d;
    logic               err_udf_q, err_udf_d;

    logic [ADDR_BITS:0] used;
    logic [ADDR_BITS:0] wr_ptr_post;
    logic               full_w, empty_w;
    logic               wr_acc, wr_rej, rd_acc, rd_rej;

    assign used    = wr_ptr_q - rd_ptr_q;
    assign full_w  = (used == DEPTH_W);
    assign empty_w = (commit_ptr_q == rd_ptr_q);

    // A discard swallows any same-cycle write silently, so it can never raise an overflow.
    assign wr_acc = wr_en && !full_w && !wr_discard;
    assign wr_rej = wr_en &&  full_w && !wr_discard;
    assign rd_acc = rd_en && !empty_w;
    assign rd_rej = rd_en &&  empty_w;

    assign wr_ptr_post = wr_acc ? (wr_ptr_q + ONE_W) : wr_ptr_q;

    always_comb begin
        wr_ptr_d     = wr_discard ? commit_ptr_q : wr_ptr_post;
        commit_ptr_d = (wr_commit && !wr_discard) ? wr_ptr_post : commit_ptr_q;
        rd_ptr_d     = rd_acc ? (rd_ptr_q + ONE_W) : rd_ptr_q;
        err_ovf_d    = wr_rej || (err_ovf_q && !err_clr);
        err_udf_d    = rd_rej || (err_udf_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_udf_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= rd_acc;
            err_ovf_q    <= err_ovf_d;
            err_udf_q    <= err_udf_d;
            if (rd_acc) begin
                rd_data_q <= mem_q[rd_ptr_q[ADDR_BITS-1:0]];
            end
        end
    end

    assign full        = full_w;
    assign empty       = empty_w;
    assign free        = DEPTH_W - used;
    assign count       = commit_ptr_q - rd_ptr_q;
    assign almost_full = (32'(free) <= AFULL_THRESH);
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign err_ovf     = err_ovf_q;
    assign err_udf     = err_udf_q;

endmodule
